// File: rtl/ghost_collision_ctrl.sv
// ghost_collision_ctrl
//   Per-frame Yoshi/ghost contact detection and damage FSM: lives counter,
//   one-cycle hit pulse, invulnerability window with sprite flashing, game over.
//   Optional macro PIXEL_COLLISION_EN: contact from per-pixel opacity flags
//   accumulated over the frame instead of tile bounding boxes.
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   i_frame_tick        1-cycle pulse per frame (start of vblank)
//   i_restart           1-cycle pulse: reload lives, return to ALIVE
//   i_y_x, i_y_y        Yoshi top-left position
//   i_g_x, i_g_y        ghost top-left positions, ghost i at [10*i+9:10*i]
//   i_ghost_en          per-ghost collidable enable
//   i_yoshi_on          Yoshi opaque at current pixel (pixel mode only)
//   i_ghost_on          ghost i opaque at current pixel (pixel mode only)
//   o_lives             remaining lives
//   o_hit_pulse         1-cycle pulse when a life is lost
//   o_hit_id            ghosts in contact at the last hit
//   o_invuln            1 while invulnerable
//   o_yoshi_blank       1 = suppress Yoshi this frame (flash)
//   o_game_over         1 while in game over
module ghost_collision_ctrl #(
   parameter int unsigned N_GHOSTS      = 3,
   parameter int unsigned T_W           = 16,
   parameter int unsigned LIVES_INIT    = 3,
   parameter int unsigned INVULN_FRAMES = 120,
   parameter int unsigned FLASH_FRAMES  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_frame_tick,
   input  logic                    i_restart,
   input  logic [9:0]              i_y_x,
   input  logic [9:0]              i_y_y,
   input  logic [10*N_GHOSTS-1:0]  i_g_x,
   input  logic [10*N_GHOSTS-1:0]  i_g_y,
   input  logic [N_GHOSTS-1:0]     i_ghost_en,
   input  logic                    i_yoshi_on,
   input  logic [N_GHOSTS-1:0]     i_ghost_on,
   output logic [2:0]              o_lives,
   output logic                    o_hit_pulse,
   output logic [N_GHOSTS-1:0]     o_hit_id,
   output logic                    o_invuln,
   output logic                    o_yoshi_blank,
   output logic                    o_game_over
);

   localparam int unsigned PW = 10;
   localparam int unsigned CW = 11;
   localparam int unsigned LW = 3;
   localparam int unsigned IW = 8;
   localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   typedef enum logic [1:0] {
      ST_ALIVE     = 2'd0,
      ST_INVULN    = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [LW-1:0]        r_lives, w_lives_nxt;
   logic                 r_hit_pulse, w_hit_pulse_nxt;
   logic [N_GHOSTS-1:0]  r_hit_id, w_hit_id_nxt;
   logic                 r_invuln;
   logic                 r_yoshi_blank, w_yoshi_blank_nxt;
   logic                 r_game_over;
   logic [IW-1:0]        r_inv_cnt, w_inv_cnt_nxt;
   logic [FW-1:0]        r_flash_cnt, w_flash_cnt_nxt;
   logic [N_GHOSTS-1:0]  w_hit_vec;

`ifdef PIXEL_COLLISION_EN
   // Sticky per-ghost pixel coincidence since the last tick
   logic [N_GHOSTS-1:0]  r_pix_hit;
   logic [N_GHOSTS-1:0]  w_pix_now;
   logic                 w_unused_box;

   assign w_pix_now    = {N_GHOSTS{i_yoshi_on}} & i_ghost_on & i_ghost_en;
   assign w_hit_vec    = r_pix_hit | w_pix_now;
   assign w_unused_box = ^{i_y_x, i_y_y, i_g_x, i_g_y};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_pix_hit <= '0;
      else if (i_restart || i_frame_tick)
         r_pix_hit <= '0;
      else
         r_pix_hit <= w_hit_vec;
   end
`else
   // Tile bounding-box overlap; 11-bit sums so positions near 1023 do not wrap
   logic [CW-1:0] w_yx, w_yy;
   logic          w_unused_pix;

   assign w_yx         = CW'(i_y_x);
   assign w_yy         = CW'(i_y_y);
   assign w_unused_pix = i_yoshi_on ^ (^i_ghost_on);

   for (genvar gi = 0; gi < N_GHOSTS; gi++) begin : g_box
      logic [CW-1:0] w_gx, w_gy;
      assign w_gx = CW'(i_g_x[PW*gi +: PW]);
      assign w_gy = CW'(i_g_y[PW*gi +: PW]);
      assign w_hit_vec[gi] = i_ghost_en[gi]
                           & (w_gx < w_yx + CW'(T_W)) & (w_yx < w_gx + CW'(T_W))
                           & (w_gy < w_yy + CW'(T_W)) & (w_yy < w_gy + CW'(T_W));
   end
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_ALIVE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and registered-output values
   always_comb begin
      w_state_nxt       = r_state;
      w_lives_nxt       = r_lives;
      w_hit_pulse_nxt   = 1'b0;
      w_hit_id_nxt      = r_hit_id;
      w_yoshi_blank_nxt = r_yoshi_blank;
      w_inv_cnt_nxt     = r_inv_cnt;
      w_flash_cnt_nxt   = r_flash_cnt;

      if (i_restart) begin
         // Restart beats a coincident frame tick
         w_state_nxt       = ST_ALIVE;
         w_lives_nxt       = LW'(LIVES_INIT);
         w_hit_id_nxt      = '0;
         w_yoshi_blank_nxt = 1'b0;
         w_inv_cnt_nxt     = '0;
         w_flash_cnt_nxt   = '0;
      end else if (i_frame_tick) begin
         case (r_state)
            ST_ALIVE: begin
               if (|w_hit_vec) begin
                  w_hit_pulse_nxt = 1'b1;
                  w_hit_id_nxt    = w_hit_vec;
                  w_lives_nxt     = r_lives - LW'(1);
                  if (r_lives == LW'(1)) begin
                     w_state_nxt = ST_GAME_OVER;
                  end else begin
                     w_state_nxt       = ST_INVULN;
                     w_inv_cnt_nxt     = IW'(INVULN_FRAMES);
                     w_flash_cnt_nxt   = '0;
                     w_yoshi_blank_nxt = 1'b0;
                  end
               end
            end
            ST_INVULN: begin
               if (r_inv_cnt == IW'(1)) begin
                  w_state_nxt       = ST_ALIVE;
                  w_inv_cnt_nxt     = '0;
                  w_flash_cnt_nxt   = '0;
                  w_yoshi_blank_nxt = 1'b0;
               end else begin
                  w_inv_cnt_nxt = r_inv_cnt - IW'(1);
                  if (r_flash_cnt == FW'(FLASH_FRAMES - 1)) begin
                     w_flash_cnt_nxt   = '0;
                     w_yoshi_blank_nxt = ~r_yoshi_blank;
                  end else begin
                     w_flash_cnt_nxt = r_flash_cnt + FW'(1);
                  end
               end
            end
            ST_GAME_OVER: begin
               w_yoshi_blank_nxt = 1'b0;
            end
            default: begin
               w_state_nxt = ST_ALIVE;
            end
         endcase
      end
   end

   // Output and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lives       <= LW'(LIVES_INIT);
         r_hit_pulse   <= 1'b0;
         r_hit_id      <= '0;
         r_invuln      <= 1'b0;
         r_yoshi_blank <= 1'b0;
         r_game_over   <= 1'b0;
         r_inv_cnt     <= '0;
         r_flash_cnt   <= '0;
      end else begin
         r_lives       <= w_lives_nxt;
         r_hit_pulse   <= w_hit_pulse_nxt;
         r_hit_id      <= w_hit_id_nxt;
         r_invuln      <= (w_state_nxt == ST_INVULN);
         r_yoshi_blank <= w_yoshi_blank_nxt;
         r_game_over   <= (w_state_nxt == ST_GAME_OVER);
         r_inv_cnt     <= w_inv_cnt_nxt;
         r_flash_cnt   <= w_flash_cnt_nxt;
      end
   end

   assign o_lives       = r_lives;
   assign o_hit_pulse   = r_hit_pulse;
   assign o_hit_id      = r_hit_id;
   assign o_invuln      = r_invuln;
   assign o_yoshi_blank = r_yoshi_blank;
   assign o_game_over   = r_game_over;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Self-checking bench for ghost_collision_ctrl: directed vector table,
// hand-written multi-cycle sequences, and randomized stimulus against a
// frame-level reference model.
module tb_ghost_collision_ctrl;

   localparam int N   = 3;
   localparam int TW  = 16;
   localparam int LI  = 3;
   localparam int INV = 120;
   localparam int FL  = 4;
   localparam int NV  = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          tick, restart;
   logic [9:0]    y_x, y_y;
   logic [29:0]   g_x, g_y;
   logic [2:0]    ghost_en;
   logic          yoshi_on;
   logic [2:0]    ghost_on;
   logic [2:0]    o_lives;
   logic          o_hit_pulse;
   logic [2:0]    o_hit_id;
   logic          o_invuln, o_yoshi_blank, o_game_over;

   int checks   = 0;
   int failures = 0;

   // Reference model: mode 0 alive, 1 invulnerable, 2 game over;
   // m_k counts ticks elapsed since the hit that started invulnerability
   int         m_lives, m_mode, m_k;
   logic       m_pulse;
   logic [2:0] m_id, m_pix;

   always #5 clk = ~clk;

   ghost_collision_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .i_frame_tick  (tick),
      .i_restart     (restart),
      .i_y_x         (y_x),
      .i_y_y         (y_y),
      .i_g_x         (g_x),
      .i_g_y         (g_y),
      .i_ghost_en    (ghost_en),
      .i_yoshi_on    (yoshi_on),
      .i_ghost_on    (ghost_on),
      .o_lives       (o_lives),
      .o_hit_pulse   (o_hit_pulse),
      .o_hit_id      (o_hit_id),
      .o_invuln      (o_invuln),
      .o_yoshi_blank (o_yoshi_blank),
      .o_game_over   (o_game_over)
   );

   typedef struct {
      bit         rs;
      bit         tk;
      logic [9:0] yx, yy;
      logic [29:0] gx, gy;
      logic [2:0] en;
      int         e_lives;
      bit         e_pulse;
      logic [2:0] e_id;
      bit         e_inv;
      bit         e_go;
   } vec_t;

   vec_t vecs [NV];

   function automatic logic [29:0] pk3(input int a, input int b, input int c);
      return {10'(c), 10'(b), 10'(a)};
   endfunction

   function automatic vec_t mk(input bit rs, input bit tk, input int yx, input int yy,
                               input logic [29:0] gx, input logic [29:0] gy, input logic [2:0] en,
                               input int el, input bit ep, input logic [2:0] eid,
                               input bit ei, input bit eg);
      vec_t v;
      v.rs = rs; v.tk = tk; v.yx = 10'(yx); v.yy = 10'(yy); v.gx = gx; v.gy = gy; v.en = en;
      v.e_lives = el; v.e_pulse = ep; v.e_id = eid; v.e_inv = ei; v.e_go = eg;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_contact();
      logic [2:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
`ifdef PIXEL_COLLISION_EN
         v[i] = m_pix[i] | (yoshi_on & ghost_on[i] & ghost_en[i]);
`else
         int gx, gy, yx, yy;
         gx = int'(g_x[10*i +: 10]);
         gy = int'(g_y[10*i +: 10]);
         yx = int'(y_x);
         yy = int'(y_y);
         v[i] = ghost_en[i] && (gx < yx + TW) && (yx < gx + TW) && (gy < yy + TW) && (yy < gy + TW);
`endif
      end
      return v;
   endfunction

   task automatic model_reset();
      m_lives = LI; m_mode = 0; m_k = 0; m_pulse = 1'b0; m_id = '0; m_pix = '0;
   endtask

   // Advance the model by the clock edge about to happen
   task automatic model_update();
      logic [2:0] v;
      v = model_contact();
      m_pulse = 1'b0;
      if (restart) begin
         m_lives = LI; m_mode = 0; m_k = 0; m_id = '0; m_pix = '0;
      end else if (tick) begin
         if (m_mode == 0 && v != 3'b000) begin
            m_pulse = 1'b1;
            m_id    = v;
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = 2;
            else begin m_mode = 1; m_k = 0; end
         end else if (m_mode == 1) begin
            m_k = m_k + 1;
            if (m_k == INV) m_mode = 0;
         end
         m_pix = '0;
      end else begin
         m_pix = v;
      end
   endtask

   task automatic check_model();
      int eb;
      eb = (m_mode == 1) ? ((m_k / FL) % 2) : 0;
      chk("m_lives", int'(o_lives), m_lives);
      chk("m_pulse", int'(o_hit_pulse), int'(m_pulse));
      chk("m_hit_id", int'(o_hit_id), int'(m_id));
      chk("m_invuln", int'(o_invuln), (m_mode == 1) ? 1 : 0);
      chk("m_blank", int'(o_yoshi_blank), eb);
      chk("m_game_over", int'(o_game_over), (m_mode == 2) ? 1 : 0);
   endtask

   // One clock: inputs already driven, compare on the following falling edge
   task automatic step();
      model_update();
      @(negedge clk);
      check_model();
   endtask

   task automatic tick_pair();
      tick = 1'b1; step(); tick = 1'b0; step();
   endtask

   task automatic set_contact_scene();
      y_x = 10'(100); y_y = 10'(100);
      g_x = pk3(115, 500, 500); g_y = pk3(100, 400, 400);
      ghost_en = 3'b001; yoshi_on = 1'b1; ghost_on = 3'b111;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; restart = 1'b0;
      y_x = '0; y_y = '0; g_x = '0; g_y = '0; ghost_en = '0; yoshi_on = 1'b0; ghost_on = '0;
      model_reset();

      vecs[0]  = mk(0, 1, 100, 100, pk3(116, 500, 500), pk3(100, 400, 400), 3'b001, 3, 0, 3'b000, 0, 0);
      vecs[1]  = mk(0, 1, 100, 100, pk3(100, 500, 500), pk3(116, 400, 400), 3'b001, 3, 0, 3'b000, 0, 0);
      vecs[2]  = mk(0, 0, 100, 100, pk3(115, 500, 500), pk3(100, 400, 400), 3'b001, 3, 0, 3'b000, 0, 0);
      vecs[3]  = mk(0, 1, 100, 100, pk3(115, 500, 500), pk3(100, 400, 400), 3'b001, 2, 1, 3'b001, 1, 0);
      vecs[4]  = mk(0, 0, 100, 100, pk3(115, 500, 500), pk3(100, 400, 400), 3'b001, 2, 0, 3'b001, 1, 0);
      vecs[5]  = mk(1, 0, 100, 100, pk3(115, 500, 500), pk3(100, 400, 400), 3'b001, 3, 0, 3'b000, 0, 0);
      vecs[6]  = mk(0, 1, 100, 100, pk3(85, 100, 110),  pk3(85, 100, 110),  3'b101, 2, 1, 3'b101, 1, 0);
      vecs[7]  = mk(1, 0, 100, 100, pk3(85, 100, 110),  pk3(85, 100, 110),  3'b101, 3, 0, 3'b000, 0, 0);
      vecs[8]  = mk(0, 1, 100, 100, pk3(100, 100, 100), pk3(100, 100, 100), 3'b000, 3, 0, 3'b000, 0, 0);
      vecs[9]  = mk(0, 1, 100, 100, pk3(500, 84, 500),  pk3(400, 100, 400), 3'b010, 3, 0, 3'b000, 0, 0);
      vecs[10] = mk(0, 1, 100, 100, pk3(500, 100, 500), pk3(400, 84, 400),  3'b010, 3, 0, 3'b000, 0, 0);
      vecs[11] = mk(0, 1, 1015, 100, pk3(500, 1000, 500), pk3(400, 100, 400), 3'b010, 2, 1, 3'b010, 1, 0);

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst_lives", int'(o_lives), LI);
      chk("rst_pulse", int'(o_hit_pulse), 0);
      chk("rst_hit_id", int'(o_hit_id), 0);
      chk("rst_invuln", int'(o_invuln), 0);
      chk("rst_blank", int'(o_yoshi_blank), 0);
      chk("rst_game_over", int'(o_game_over), 0);
      reset = 1'b0;

`ifndef PIXEL_COLLISION_EN
      // Directed bounding-box vectors, one clock each
      for (int n = 0; n < NV; n++) begin
         restart = vecs[n].rs; tick = vecs[n].tk;
         y_x = vecs[n].yx; y_y = vecs[n].yy; g_x = vecs[n].gx; g_y = vecs[n].gy;
         ghost_en = vecs[n].en;
         step();
         chk($sformatf("v%0d_lives", n), int'(o_lives), vecs[n].e_lives);
         chk($sformatf("v%0d_pulse", n), int'(o_hit_pulse), int'(vecs[n].e_pulse));
         chk($sformatf("v%0d_hit_id", n), int'(o_hit_id), int'(vecs[n].e_id));
         chk($sformatf("v%0d_invuln", n), int'(o_invuln), int'(vecs[n].e_inv));
         chk($sformatf("v%0d_game_over", n), int'(o_game_over), int'(vecs[n].e_go));
         restart = 1'b0; tick = 1'b0;
      end
`endif

      // Invulnerability window with held contact, then the next hit
      restart = 1'b1; step(); restart = 1'b0;
      set_contact_scene();
      tick = 1'b1; step(); tick = 1'b0;
      chk("inv_hit_lives", int'(o_lives), 2);
      chk("inv_hit_pulse", int'(o_hit_pulse), 1);
      chk("inv_hit_id", int'(o_hit_id), 1);
      chk("inv_hit_invuln", int'(o_invuln), 1);
      step();
      chk("inv_pulse_drop", int'(o_hit_pulse), 0);
      for (int k = 1; k <= INV; k++) begin
         tick = 1'b1; step(); tick = 1'b0;
         chk($sformatf("inv_k%0d_lives", k), int'(o_lives), 2);
         chk($sformatf("inv_k%0d_invuln", k), int'(o_invuln), (k < INV) ? 1 : 0);
         chk($sformatf("inv_k%0d_blank", k), int'(o_yoshi_blank), (k < INV) ? ((k / FL) % 2) : 0);
         step();
      end
      tick = 1'b1; step(); tick = 1'b0;
      chk("tick121_lives", int'(o_lives), 1);
      chk("tick121_pulse", int'(o_hit_pulse), 1);
      step();

      // Last life lost, sticky game over, restart beating a tick
      for (int k = 1; k <= INV; k++) tick_pair();
      tick = 1'b1; step(); tick = 1'b0;
      chk("go_lives", int'(o_lives), 0);
      chk("go_flag", int'(o_game_over), 1);
      chk("go_pulse", int'(o_hit_pulse), 1);
      step();
      for (int k = 0; k < 5; k++) tick_pair();
      chk("go_sticky_lives", int'(o_lives), 0);
      chk("go_sticky_flag", int'(o_game_over), 1);
      restart = 1'b1; tick = 1'b1; step(); restart = 1'b0; tick = 1'b0;
      chk("rs_tick_lives", int'(o_lives), LI);
      chk("rs_tick_go", int'(o_game_over), 0);
      chk("rs_tick_pulse", int'(o_hit_pulse), 0);
      chk("rs_tick_id", int'(o_hit_id), 0);
      chk("rs_tick_invuln", int'(o_invuln), 0);
      tick = 1'b1; step(); tick = 1'b0;
      chk("first_alive_tick_lives", int'(o_lives), 2);

      // Asynchronous reset in the middle of invulnerability
      for (int k = 0; k < 5; k++) tick_pair();
      reset = 1'b1;
      #1;
      chk("arst_lives", int'(o_lives), LI);
      chk("arst_invuln", int'(o_invuln), 0);
      chk("arst_blank", int'(o_yoshi_blank), 0);
      chk("arst_hit_id", int'(o_hit_id), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

`ifdef PIXEL_COLLISION_EN
      // Boxes overlap but opaque pixels never coincide, then one coincident pixel
      set_contact_scene();
      yoshi_on = 1'b1; ghost_on = 3'b000; step(); step();
      yoshi_on = 1'b0; ghost_on = 3'b001; step(); step();
      yoshi_on = 1'b1; ghost_on = 3'b000; tick = 1'b1; step(); tick = 1'b0;
      chk("pix_nohit_lives", int'(o_lives), LI);
      chk("pix_nohit_pulse", int'(o_hit_pulse), 0);
      yoshi_on = 1'b1; ghost_on = 3'b001; step();
      yoshi_on = 1'b0; ghost_on = 3'b000; step(); step();
      tick = 1'b1; step(); tick = 1'b0;
      chk("pix_hit_lives", int'(o_lives), LI - 1);
      chk("pix_hit_pulse", int'(o_hit_pulse), 1);
      chk("pix_hit_id", int'(o_hit_id), 1);
      for (int k = 1; k <= INV; k++) tick_pair();
      tick = 1'b1; step(); tick = 1'b0;
      chk("pix_cleared_lives", int'(o_lives), LI - 1);
      chk("pix_cleared_pulse", int'(o_hit_pulse), 0);
      restart = 1'b1; step(); restart = 1'b0;
`endif

      // Randomized stimulus against the model
      for (int c = 0; c < 4000; c++) begin
         tick    = ($urandom_range(0, 2) == 0);
         restart = ($urandom_range(0, 299) == 0);
         y_x = 10'($urandom_range(0, 1023));
         y_y = 10'($urandom_range(0, 1023));
         for (int i = 0; i < N; i++) begin
            int tx, ty;
            tx = int'(y_x) + int'($urandom_range(0, 40)) - 20;
            ty = int'(y_y) + int'($urandom_range(0, 40)) - 20;
            if (tx < 0) tx = 0;
            if (tx > 1023) tx = 1023;
            if (ty < 0) ty = 0;
            if (ty > 1023) ty = 1023;
            g_x[10*i +: 10] = 10'(tx);
            g_y[10*i +: 10] = 10'(ty);
         end
         ghost_en = 3'($urandom);
         yoshi_on = ($urandom_range(0, 3) == 0);
         ghost_on = 3'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
